// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage: bus widths, aluop/alusel codes, divider states.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package ex_pkg;

    localparam int REG_W      = 32;
    localparam int REG_ADDR_W = 5;
    localparam int ALU_OP_W   = 8;
    localparam int ALU_SEL_W  = 3;

    typedef logic [REG_W-1:0]      reg_t;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [ALU_OP_W-1:0]   aluop_t;
    typedef logic [ALU_SEL_W-1:0]  alusel_t;

    localparam logic      RstEnable    = 1'b1;
    localparam logic      WriteEnable  = 1'b1;
    localparam logic      WriteDisable = 1'b0;
    localparam reg_t      ZeroWord     = 32'h0000_0000;
    localparam reg_addr_t NOPRegAddr   = 5'b00000;

    // Operation codes
    localparam aluop_t EXE_NOP_OP  = 8'b0000_0000;
    localparam aluop_t EXE_AND_OP  = 8'b0010_0100;
    localparam aluop_t EXE_OR_OP   = 8'b0010_0101;
    localparam aluop_t EXE_XOR_OP  = 8'b0010_0110;
    localparam aluop_t EXE_NOR_OP  = 8'b0010_0111;
    localparam aluop_t EXE_SLL_OP  = 8'b0111_1100;
    localparam aluop_t EXE_SRL_OP  = 8'b0000_0010;
    localparam aluop_t EXE_SRA_OP  = 8'b0000_0011;
    localparam aluop_t EXE_ADD_OP  = 8'b0010_0000;
    localparam aluop_t EXE_ADDU_OP = 8'b0010_0001;
    localparam aluop_t EXE_SUB_OP  = 8'b0010_0010;
    localparam aluop_t EXE_SUBU_OP = 8'b0010_0011;
    localparam aluop_t EXE_SLT_OP  = 8'b0010_1010;
    localparam aluop_t EXE_SLTU_OP = 8'b0010_1011;
    localparam aluop_t EXE_MFHI_OP = 8'b0001_0000;
    localparam aluop_t EXE_MTHI_OP = 8'b0001_0001;
    localparam aluop_t EXE_MFLO_OP = 8'b0001_0010;
    localparam aluop_t EXE_MTLO_OP = 8'b0001_0011;
    localparam aluop_t EXE_DIV_OP  = 8'b0001_1010;
    localparam aluop_t EXE_DIVU_OP = 8'b0001_1011;

    // Result classes
    localparam alusel_t EXE_RES_NOP        = 3'b000;
    localparam alusel_t EXE_RES_LOGIC      = 3'b001;
    localparam alusel_t EXE_RES_SHIFT      = 3'b010;
    localparam alusel_t EXE_RES_MOVE       = 3'b011;
    localparam alusel_t EXE_RES_ARITHMETIC = 3'b100;

    // Divider FSM encodings
    localparam logic [1:0] DivFree   = 2'b00;
    localparam logic [1:0] DivByZero = 2'b01;
    localparam logic [1:0] DivOn     = 2'b10;
    localparam logic [1:0] DivEnd    = 2'b11;

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;

    function automatic logic is_div_op(input aluop_t op);
        return (op == EXE_DIV_OP) || (op == EXE_DIVU_OP);
    endfunction

endpackage

// File: rtl/ex_div.sv
// Iterative restoring divider, one quotient bit per cycle, with signed pre/post correction.
// Latency: 34 cycles from start (Free, 32x On, End); 3 cycles for a zero divisor.
// Backpressure: none; start_i is honoured only in Free, annul_i returns to Free on any edge.
// Ports: clk, rst (sync, active-high), signed_div_i, opdata1_i (dividend), opdata2_i (divisor),
//        start_i, annul_i -> result_o {remainder, quotient} valid while ready_o is high.
module ex_div
    import ex_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o
);

    logic [1:0]  state;
    logic [5:0]  cnt;
    logic [64:0] work;      // {partial remainder (33b), dividend/quotient (32b)}
    logic [31:0] dsor;
    logic        neg_q;
    logic        neg_r;

    logic [31:0] op1_abs;
    logic [31:0] op2_abs;
    logic [64:0] shifted;
    logic [32:0] diff;
    logic [31:0] quot;
    logic [31:0] rem;

    always_comb begin
        op1_abs = (signed_div_i && opdata1_i[31]) ? (32'd0 - opdata1_i) : opdata1_i;
        op2_abs = (signed_div_i && opdata2_i[31]) ? (32'd0 - opdata2_i) : opdata2_i;
        shifted = work << 1;
        // Trial subtraction; a set sign bit means the divisor does not fit.
        diff    = shifted[64:32] - {1'b0, dsor};
        quot    = work[31:0];
        rem     = work[63:32];
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state <= DivFree;
            cnt   <= 6'd0;
            work  <= '0;
            dsor  <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (annul_i) begin
            state <= DivFree;
        end else begin
            case (state)
                DivFree: begin
                    if (start_i) begin
                        cnt <= 6'd0;
                        if (opdata2_i == 32'd0) begin
                            state <= DivByZero;
                            work  <= '0;
                            dsor  <= '0;
                            neg_q <= 1'b0;
                            neg_r <= 1'b0;
                        end else begin
                            state <= DivOn;
                            work  <= {33'd0, op1_abs};
                            dsor  <= op2_abs;
                            neg_q <= signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
                            neg_r <= signed_div_i & opdata1_i[31];
                        end
                    end
                end
                DivByZero: begin
                    state <= DivEnd;
                end
                DivOn: begin
                    if (diff[32]) begin
                        work <= shifted;
                    end else begin
                        work <= {diff, shifted[31:1], 1'b1};
                    end
                    cnt <= cnt + 6'd1;
                    if (cnt == 6'd31) begin
                        state <= DivEnd;
                    end
                end
                DivEnd: begin
                    state <= DivFree;
                end
                default: begin
                    state <= DivFree;
                end
            endcase
        end
    end

    // Quotient sign follows the operand signs; remainder sign follows the dividend.
    assign result_o = {(neg_r ? (32'd0 - rem) : rem), (neg_q ? (32'd0 - quot) : quot)};
    assign ready_o  = (state == DivEnd) ? DivResultReady : DivResultNotReady;

endmodule

// File: rtl/ex.sv
// Execute stage: logic/shift/arith/move in one combinational pass, DIV/DIVU via iterative divider.
// Latency: 0 cycles for non-divide ops; 34 cycles for DIV/DIVU (3 on a zero divisor).
// Backpressure: stallreq_o holds the front of the pipe while a divide is busy; flush_i drops it at once.
// Ports: aluop_i/alusel_i/reg1_i/reg2_i/wd_i/wreg_i/hi_i/lo_i from ID/EX, flush_i;
//        wd_o/wreg_o/wdata_o (GPR write), whilo_o/hi_o/lo_o (HI/LO write), stallreq_o.
// Build option: EX_DIV_EN compiles in the divider; without it DIV/DIVU are NOPs and stall is tied low.
module ex
    import ex_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ALU_OP_W-1:0]   aluop_i,
    input  logic [ALU_SEL_W-1:0]  alusel_i,
    input  logic [REG_W-1:0]      reg1_i,
    input  logic [REG_W-1:0]      reg2_i,
    input  logic [REG_ADDR_W-1:0] wd_i,
    input  logic                  wreg_i,
    input  logic [REG_W-1:0]      hi_i,
    input  logic [REG_W-1:0]      lo_i,
    input  logic                  flush_i,
    output logic [REG_ADDR_W-1:0] wd_o,
    output logic                  wreg_o,
    output logic [REG_W-1:0]      wdata_o,
    output logic                  whilo_o,
    output logic [REG_W-1:0]      hi_o,
    output logic [REG_W-1:0]      lo_o,
    output logic                  stallreq_o
);

    logic        is_div;
    logic        div_ready;
    logic [63:0] div_result;
    logic        div_busy;

    logic [31:0] logic_res;
    logic [31:0] shift_res;
    logic [31:0] arith_res;
    logic [31:0] move_res;
    logic [31:0] b_op;
    logic [31:0] sum;
    logic        ovf_add;
    logic        ovf_sub;
    logic        trap;

    assign is_div = is_div_op(aluop_i);

`ifdef EX_DIV_EN
    ex_div u_div (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (aluop_i == EXE_DIV_OP),
        .opdata1_i    (reg1_i),
        .opdata2_i    (reg2_i),
        .start_i      (is_div),
        .annul_i      (flush_i),
        .result_o     (div_result),
        .ready_o      (div_ready)
    );
    // ID/EX holds the divide op in place, so "divide op present and result not ready" covers
    // the Free, ByZero and On cycles.
    assign div_busy = is_div && (div_ready != DivResultReady);
`else
    logic unused_clk;
    assign unused_clk = clk;   // clk only feeds the divider
    assign div_ready  = DivResultNotReady;
    assign div_result = 64'd0;
    assign div_busy   = 1'b0;
`endif

    always_comb begin
        logic_res = ZeroWord;
        case (aluop_i)
            EXE_OR_OP:  logic_res = reg1_i | reg2_i;
            EXE_AND_OP: logic_res = reg1_i & reg2_i;
            EXE_XOR_OP: logic_res = reg1_i ^ reg2_i;
            EXE_NOR_OP: logic_res = ~(reg1_i | reg2_i);
            default:    logic_res = ZeroWord;
        endcase
    end

    always_comb begin
        shift_res = ZeroWord;
        case (aluop_i)
            EXE_SLL_OP: shift_res = reg2_i << reg1_i[4:0];
            EXE_SRL_OP: shift_res = reg2_i >> reg1_i[4:0];
            EXE_SRA_OP: shift_res = $unsigned($signed(reg2_i) >>> reg1_i[4:0]);
            default:    shift_res = ZeroWord;
        endcase
    end

    always_comb begin
        b_op    = ((aluop_i == EXE_SUB_OP) || (aluop_i == EXE_SUBU_OP)) ? (~reg2_i + 32'd1) : reg2_i;
        sum     = reg1_i + b_op;
        // Overflow judged on the original operand signs, so SUB of 0x80000000 is handled.
        ovf_add = (reg1_i[31] == reg2_i[31]) && (sum[31] != reg1_i[31]);
        ovf_sub = (reg1_i[31] != reg2_i[31]) && (sum[31] != reg1_i[31]);
        trap    = ((aluop_i == EXE_ADD_OP) && ovf_add) || ((aluop_i == EXE_SUB_OP) && ovf_sub);
        arith_res = ZeroWord;
        case (aluop_i)
            EXE_ADD_OP, EXE_ADDU_OP,
            EXE_SUB_OP, EXE_SUBU_OP: arith_res = sum;
            EXE_SLT_OP:  arith_res = {31'd0, $signed(reg1_i) < $signed(reg2_i)};
            EXE_SLTU_OP: arith_res = {31'd0, reg1_i < reg2_i};
            default:     arith_res = ZeroWord;
        endcase
    end

    always_comb begin
        move_res = ZeroWord;
        case (aluop_i)
            EXE_MFHI_OP: move_res = hi_i;
            EXE_MFLO_OP: move_res = lo_i;
            default:     move_res = ZeroWord;
        endcase
    end

    always_comb begin
        wd_o       = NOPRegAddr;
        wreg_o     = WriteDisable;
        wdata_o    = ZeroWord;
        whilo_o    = WriteDisable;
        hi_o       = ZeroWord;
        lo_o       = ZeroWord;
        stallreq_o = 1'b0;
        if (rst != RstEnable) begin
            wd_o = wd_i;
            if (is_div || trap) begin
                wreg_o = WriteDisable;
            end else begin
                wreg_o = wreg_i;
            end
            case (alusel_i)
                EXE_RES_LOGIC:      wdata_o = logic_res;
                EXE_RES_SHIFT:      wdata_o = shift_res;
                EXE_RES_ARITHMETIC: wdata_o = arith_res;
                EXE_RES_MOVE:       wdata_o = move_res;
                default:            wdata_o = ZeroWord;
            endcase
            if (aluop_i == EXE_MTHI_OP) begin
                whilo_o = WriteEnable;
                hi_o    = reg1_i;
                lo_o    = lo_i;
            end else if (aluop_i == EXE_MTLO_OP) begin
                whilo_o = WriteEnable;
                hi_o    = hi_i;
                lo_o    = reg1_i;
            end else if (is_div && (div_ready == DivResultReady) && !flush_i) begin
                // A flush landing on the End cycle discards the result.
                whilo_o = WriteEnable;
                hi_o    = div_result[63:32];
                lo_o    = div_result[31:0];
            end
            stallreq_o = div_busy && !flush_i;
        end
    end

endmodule
